// File: rtl/product_tc_restore.sv
// Result-side sign restoration for the vector Vedic multiplier: per-lane two's complement
// of the unsigned magnitude product, low/high half select, 2-stage valid/ready pipeline.
module product_tc_restore #(
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           opcode,
    input  logic [1:0]           precision,
    input  logic [3:0]           sign_a,
    input  logic [3:0]           sign_b,
    input  logic [63:0]          product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          result,
    output logic [cnt_width-1:0] txn_count
);

    localparam logic [1:0] PREC_16 = 2'b01;
    localparam logic [1:0] PREC_32 = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b00;

    logic        rst_done;
    logic        s1_valid;
    logic        s2_valid;
    logic        s1_adv;
    logic        s2_adv;
    logic        in_fire;
    logic        out_fire;
    logic [63:0] s1_product;
    logic [1:0]  s1_opcode;
    logic [1:0]  s1_precision;
    logic [3:0]  s1_neg;
    logic [3:0]  in_neg;
    logic [31:0] s2_next;
    logic        take_high;
    logic [15:0] lane_8;
    logic [31:0] lane_16;
    logic [63:0] lane_32;

    assign s2_adv    = !s2_valid | out_ready;
    assign s1_adv    = !s1_valid | s2_adv;
    // rst_done keeps in_ready low until the first edge after reset release
    assign in_ready  = s1_adv & rst_done & rst_n;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = s2_valid & out_ready;
    assign out_valid = s2_valid;

    // Only the MSB-byte sign of each lane decides its negation in wider precisions
    always_comb begin
        in_neg = 4'b0000;
        case (precision)
            PREC_16: in_neg[1:0] = {sign_a[3] ^ sign_b[3], sign_a[1] ^ sign_b[1]};
            PREC_32: in_neg[0]   = sign_a[3] ^ sign_b[3];
            default: in_neg      = sign_a ^ sign_b;
        endcase
    end

    always_comb begin
        s2_next   = 32'h0;
        take_high = (s1_opcode != OP_MUL);
        lane_8    = 16'h0;
        lane_16   = 32'h0;
        lane_32   = 64'h0;
        case (s1_precision)
            PREC_16: begin
                for (int j = 0; j < 2; j++) begin
                    lane_16 = s1_product[32*j +: 32];
                    if (s1_neg[j]) lane_16 = ~lane_16 + 32'd1;
                    s2_next[16*j +: 16] = take_high ? lane_16[31:16] : lane_16[15:0];
                end
            end
            PREC_32: begin
                lane_32 = s1_product;
                if (s1_neg[0]) lane_32 = ~lane_32 + 64'd1;
                s2_next = take_high ? lane_32[63:32] : lane_32[31:0];
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    lane_8 = s1_product[16*i +: 16];
                    if (s1_neg[i]) lane_8 = ~lane_8 + 16'd1;
                    s2_next[8*i +: 8] = take_high ? lane_8[15:8] : lane_8[7:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done     <= 1'b0;
            s1_valid     <= 1'b0;
            s1_product   <= 64'h0;
            s1_opcode    <= 2'b00;
            s1_precision <= 2'b00;
            s1_neg       <= 4'b0000;
        end else begin
            rst_done <= 1'b1;
            if (s1_adv) begin
                s1_valid <= in_fire;
                if (in_fire) begin
                    s1_product   <= product;
                    s1_opcode    <= opcode;
                    s1_precision <= precision;
                    s1_neg       <= in_neg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            result    <= 32'h0;
            txn_count <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) result <= s2_next;
            end
            if (out_fire) txn_count <= txn_count + cnt_width'(1);
        end
    end

endmodule
